pwm_decode: RTL and testbench
=============================

# pwm_decode

Receive-side counterpart of the 4-bit PWM audio output. It recovers 4-bit sample values from a PWM line that uses the same frame format as the audio PWM generator. Each frame is PERIOD enable-ticks long; the line is high for the first N ticks and low for the rest, where N is the sample. The block measures high time and frame length between rising edges and emits the sample with a one-cycle valid pulse. It is used for loopback self-test of the audio path and for decoding an external PWM source on the same enable rate.

## Interface

- PERIOD, 16, frame length in enable ticks; must equal 2^SAMPLE_W.
- SAMPLE_W, 4, width of recovered sample.
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- ena  in  1  tick strobe, one clock wide; the same rate as the encoder's PWM enable.
- pwm_in  in  1  PWM line; asynchronous to clock.
- sample  out  SAMPLE_W  last recovered sample; holds between updates.
- valid  out  1  one-clock pulse when sample is updated.
- err  out  1  one-clock pulse on a malformed frame; sample is not updated.

## Operation

- Input sync: pwm_in passes through 2 flops clocked every cycle, giving pwm_s. A third flop, lvl_prev, updates only on ena ticks.
- All measurement happens on ena ticks. Non-tick cycles only move the synchronizer.
- Counters:
  - hi_cnt and per_cnt are $clog2(PERIOD)+1 bits wide and saturate at 2*PERIOD-1.
  - run_cnt counts consecutive equal levels and saturates at PERIOD.
- primed flag: 0 after reset and after any timeout. It is set by the first rising edge.
- Rising edge = a tick where pwm_s==1 and lvl_prev==0.
- States:
  - IDLE: after reset. Waits for a rising edge.
  - HIGH: the line is high within a frame.
  - LOW: the line is low within a frame.
- Transitions:
  - IDLE to HIGH on a rising edge. Set per_cnt=1, hi_cnt=1, primed=1.
  - HIGH to LOW on a tick with pwm_s==0. per_cnt increments.
  - HIGH with pwm_s==1: hi_cnt and per_cnt increment.
  - LOW with pwm_s==0: per_cnt increments.
  - LOW to HIGH on a rising edge. This closes the frame (see frame close), then set per_cnt=1, hi_cnt=1.
- Frame close, only when primed==1:
  - per_cnt==PERIOD and 1<=hi_cnt<=PERIOD-1: sample<=hi_cnt, valid pulse.
  - Anything else: err pulse, sample holds.
  - If primed==0, no output is produced and primed<=1.
- Low timeout: run_cnt reaches PERIOD with pwm_s==0 in IDLE or LOW.
  - sample<=0, valid pulse, primed<=0, state=LOW, run_cnt restarts.
  - A constant-low line therefore emits sample 0 every PERIOD ticks.
- High timeout: run_cnt reaches PERIOD with pwm_s==1. The encoder cannot produce this.
  - err pulse, primed<=0, state=HIGH, run_cnt restarts.
  - A constant-high line emits err every PERIOD ticks.
- A rising edge and a timeout cannot coincide, because a rising edge resets run_cnt to 1.
- valid and err are never high in the same cycle.

## Timing

- Reset values: sample=0, valid=0, err=0, state=IDLE, primed=0, all counters 0, sync flops 0, lvl_prev=0.
- Reset is honored mid-frame. Counters clear, primed clears, and the next frame after release is discarded as unprimed.
- Latency:
  - An edge on pwm_in reaches pwm_s 2 clocks later and is measured on the next ena tick.
  - sample, valid and err are registered. They change on the clock edge that ends the ena tick in which the closing rising edge or timeout is detected.
  - valid and err are high for exactly 1 clock.
- Throughput: at most one valid per PERIOD ticks.
- With ena held low, all state freezes except the synchronizer. Outputs hold and pulses drop after one cycle.
- Sample change by the encoder: the first frame after a change from 0 is discarded because primed==0. A change between nonzero values is decoded in the first frame carrying the new value.

## Test plan

- Loopback with the audio PWM generator, ena every 32 clocks, samples 1, 7, 15 for 3 frames each. Required: valid once per 16 ticks, sample = 1, 7, 15 in order, err never asserted.
- pwm_in held 0 after reset. Required: first valid 16 ticks after reset release with sample=0, then repeating every 16 ticks.
- Sequence 0 then 5. Required: sample=0 pulses, one discarded frame with no valid and no err, then sample=5.
- Malformed frame: high 4 ticks, low 8 ticks (12-tick period) after a good frame with value 3. Required: err pulse, sample stays 3.
- pwm_in held 1. Required: err pulse every 16 ticks, valid never, sample unchanged.
- Reset asserted at tick 8 of a value-9 frame. Required: all outputs 0 next cycle; after release, the first frame is discarded and the second gives sample=9.

Source files
------------

// File: rtl/pwm_decode.sv
// -----------------------------------------------------------------------------
// pwm_decode
//
// Receive-side decoder for the 4-bit PWM audio frame format. A frame is PERIOD
// enable ticks long. The line is high for the first N ticks and low for the
// remaining ticks, where N is the sample value. The decoder measures the high
// time and the frame length between consecutive rising edges. For each
// well-formed frame it emits the recovered sample with a one-clock valid pulse.
// A malformed frame produces a one-clock err pulse instead.
//
// Ports
//   clock_i   : system clock; all state changes on its rising edge
//   reset_i   : asynchronous, active-high reset
//   ena_i     : one-clock tick strobe at the encoder's PWM enable rate
//   pwm_in_i  : PWM line, asynchronous to clock_i
//   sample_o  : last recovered sample; holds between updates
//   valid_o   : one-clock pulse when sample_o is updated
//   err_o     : one-clock pulse on a malformed frame or a stuck-high line
//
// PERIOD must equal 2**SAMPLE_W.
// -----------------------------------------------------------------------------
module pwm_decode #(
    parameter int PERIOD   = 16,
    parameter int SAMPLE_W = 4
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                ena_i,
    input  logic                pwm_in_i,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic                valid_o,
    output logic                err_o
);

    // Frame counters need to reach 2*PERIOD-1 so that an over-long frame is
    // still distinguishable from a PERIOD-long one. The run counter only has
    // to hold PERIOD.
    localparam int CNT_W = $clog2(PERIOD) + 1;
    localparam int RUN_W = $clog2(PERIOD + 1);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(2 * PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_PERIOD = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] CNT_TOP    = CNT_W'(PERIOD - 1);
    localparam logic [RUN_W-1:0] RUN_ONE    = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_MAX    = RUN_W'(PERIOD);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    // Saturating increments
    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
        return (v == RUN_MAX) ? v : v + RUN_ONE;
    endfunction

    // Synchronizer; runs every clock regardless of ena_i
    logic sync1_q;
    logic pwm_s_q;

    // Measurement state
    state_t              state_q,    state_d;
    logic                lvl_prev_q, lvl_prev_d;
    logic [CNT_W-1:0]    hi_q,       hi_d;
    logic [CNT_W-1:0]    per_q,      per_d;
    logic [RUN_W-1:0]    run_q,      run_d;
    logic                primed_q,   primed_d;
    logic [SAMPLE_W-1:0] sample_q,   sample_d;
    logic                valid_q,    valid_d;
    logic                err_q,      err_d;

    // Per-tick decode terms
    logic             rise;
    logic [RUN_W-1:0] run_next;
    logic             timeout;
    logic             frame_ok;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            pwm_s_q <= 1'b0;
        end else begin
            sync1_q <= pwm_in_i;
            pwm_s_q <= sync1_q;
        end
    end

    assign rise = pwm_s_q & ~lvl_prev_q;

    // A level change restarts the run at 1; a repeated level extends it.
    assign run_next = (pwm_s_q == lvl_prev_q) ? sat_inc_run(run_q) : RUN_ONE;
    assign timeout  = (run_next == RUN_MAX);

    // A good frame is exactly PERIOD ticks with a high time in 1..PERIOD-1.
    // Sample 0 never produces a rising edge, so it is reported via the low
    // timeout instead of a frame close.
    assign frame_ok = (per_q == CNT_PERIOD) && (hi_q != '0) && (hi_q <= CNT_TOP);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            lvl_prev_q <= 1'b0;
            hi_q       <= '0;
            per_q      <= '0;
            run_q      <= '0;
            primed_q   <= 1'b0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lvl_prev_q <= lvl_prev_d;
            hi_q       <= hi_d;
            per_q      <= per_d;
            run_q      <= run_d;
            primed_q   <= primed_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lvl_prev_d = lvl_prev_q;
        hi_d       = hi_q;
        per_d      = per_q;
        run_d      = run_q;
        primed_d   = primed_q;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        if (ena_i) begin
            lvl_prev_d = pwm_s_q;
            run_d      = run_next;

            unique case (state_q)
                ST_IDLE: begin
                    // First edge after reset opens a frame but has nothing
                    // to close yet.
                    if (rise) begin
                        state_d  = ST_HIGH;
                        per_d    = CNT_ONE;
                        hi_d     = CNT_ONE;
                        primed_d = 1'b1;
                    end
                end

                ST_HIGH: begin
                    per_d = sat_inc_cnt(per_q);
                    if (pwm_s_q) begin
                        hi_d = sat_inc_cnt(hi_q);
                    end else begin
                        state_d = ST_LOW;
                    end
                end

                ST_LOW: begin
                    if (rise) begin
                        // Close the frame that started at the previous edge.
                        // An unprimed frame began before a timeout or reset
                        // and cannot be trusted, so it is silently dropped.
                        if (primed_q) begin
                            if (frame_ok) begin
                                sample_d = hi_q[SAMPLE_W-1:0];
                                valid_d  = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        primed_d = 1'b1;
                        state_d  = ST_HIGH;
                        per_d    = CNT_ONE;
                        hi_d     = CNT_ONE;
                    end else begin
                        per_d = sat_inc_cnt(per_q);
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // A full frame at one level. Cannot coincide with a rising edge,
            // since an edge restarts the run at 1, so the frame-close
            // outputs above are never overridden here.
            if (timeout) begin
                run_d    = '0;
                primed_d = 1'b0;
                if (pwm_s_q) begin
                    err_d   = 1'b1;
                    state_d = ST_HIGH;
                end else begin
                    sample_d = '0;
                    valid_d  = 1'b1;
                    state_d  = ST_LOW;
                end
            end
        end
    end

    assign sample_o = sample_q;
    assign valid_o  = valid_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_pwm_decode.sv
module tb_pwm_decode;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       pwm_in;
    logic [3:0] sample_o;
    logic       valid_o;
    logic       err_o;

    pwm_decode #(.PERIOD(16), .SAMPLE_W(4)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .ena_i   (ena),
        .pwm_in_i(pwm_in),
        .sample_o(sample_o),
        .valid_o (valid_o),
        .err_o   (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int div   = 4;
    int tk    = 0;
    bit chk_en = 1'b0;

    logic       rec_v [0:255];
    logic       rec_e [0:255];
    logic [3:0] rec_s [0:255];

    // Behavioural model: works on tick indices, not on a state machine.
    logic       m_prev;
    int         m_run;
    bit         m_primed;
    int         m_t;
    int         m_trise;
    int         m_hi;
    logic [3:0] exp_sample;
    logic       exp_valid;
    logic       exp_err;

    task automatic model_reset();
        m_prev = 1'b0; m_run = 0; m_primed = 1'b0;
        m_t = 0; m_trise = 0; m_hi = 0;
        exp_sample = 4'd0; exp_valid = 1'b0; exp_err = 1'b0;
    endtask

    task automatic model_tick(input logic s);
        int run, per, hi;
        if (!rst) begin
            m_t++;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            run = (s == m_prev) ? ((m_run + 1 > 16) ? 16 : m_run + 1) : 1;
            if (s && !m_prev) begin
                if (m_primed) begin
                    per = (m_t - m_trise > 31) ? 31 : m_t - m_trise;
                    hi  = (m_hi > 31) ? 31 : m_hi;
                    if (per == 16 && hi >= 1 && hi <= 15) begin
                        exp_valid  = 1'b1;
                        exp_sample = 4'(hi);
                    end else begin
                        exp_err = 1'b1;
                    end
                end
                m_primed = 1'b1;
                m_trise  = m_t;
                m_hi     = 1;
            end else if (s) begin
                m_hi++;
            end
            if (run == 16) begin
                if (s) exp_err = 1'b1;
                else begin
                    exp_valid  = 1'b1;
                    exp_sample = 4'd0;
                end
                m_primed = 1'b0;
                run      = 0;
            end
            m_run  = run;
            m_prev = s;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if (valid_o !== exp_valid || err_o !== exp_err || sample_o !== exp_sample) begin
                n_bad++;
                $display("FAIL cycle_cmp t=%0t got valid=%b err=%b sample=%0d required valid=%b err=%b sample=%0d",
                         $time, valid_o, err_o, sample_o, exp_valid, exp_err, exp_sample);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // One ena tick every div clocks; starts and ends on a falling edge.
    task automatic do_tick(input logic lvl);
        pwm_in = lvl;
        repeat (div - 2) @(negedge clk);
        ena = 1'b1;
        @(posedge clk);
        #1;
        model_tick(lvl);
        @(negedge clk);
        ena = 1'b0;
        tk++;
        if (tk < 256) begin
            rec_v[tk] = valid_o;
            rec_e[tk] = err_o;
            rec_s[tk] = sample_o;
        end
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input int hi, input int len);
        for (int i = 0; i < len; i++) do_tick(i < hi);
    endtask

    task automatic assert_rst();
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_test(input int d);
        div    = d;
        pwm_in = 1'b0;
        assert_rst();
        repeat (2) @(negedge clk);
        release_rst();
        tk = 0;
    endtask

    int got[$];
    int exp_seq[9] = '{1, 1, 1, 7, 7, 7, 15, 15, 15};
    int vals[10]   = '{1, 1, 1, 7, 7, 7, 15, 15, 15, 15};
    int cnt_v, cnt_e;

    initial begin
        rst = 1'b1; ena = 1'b0; pwm_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_sample", sample_o, 0);
        chk("reset_valid", valid_o, 0);
        chk("reset_err", err_o, 0);

        // Loopback, ena every 32 clocks
        start_test(32);
        for (int f = 0; f < 10; f++) send_frame(vals[f], 16);
        got.delete(); cnt_e = 0;
        for (int i = 1; i <= tk; i++) begin
            if (rec_v[i]) got.push_back(int'(rec_s[i]));
            if (rec_e[i]) cnt_e++;
        end
        chk("loop_valid_count", got.size(), 9);
        chk("loop_err_count", cnt_e, 0);
        for (int k = 0; k < 9; k++)
            if (k < got.size()) chk("loop_sample_seq", got[k], exp_seq[k]);
        for (int k = 0; k < 9; k++) chk("loop_valid_tick", int'(rec_v[17 + 16 * k]), 1);
        chk("model_pin_loop_sample", int'(exp_sample), 15);

        // Constant low line
        start_test(4);
        for (int i = 0; i < 48; i++) do_tick(1'b0);
        for (int i = 1; i <= 48; i++) begin
            chk("low_valid", int'(rec_v[i]), (i % 16 == 0) ? 1 : 0);
            chk("low_err", int'(rec_e[i]), 0);
        end
        chk("low_sample16", int'(rec_s[16]), 0);

        // Sample 0 then 5
        start_test(4);
        for (int i = 0; i < 20; i++) do_tick(1'b0);
        for (int f = 0; f < 3; f++) send_frame(5, 16);
        do_tick(1'b1);
        chk("z5_valid16", int'(rec_v[16]), 1);
        chk("z5_sample16", int'(rec_s[16]), 0);
        chk("z5_discard_valid", int'(rec_v[21]), 0);
        chk("z5_discard_err", int'(rec_e[21]), 0);
        chk("z5_valid37", int'(rec_v[37]), 1);
        chk("z5_sample37", int'(rec_s[37]), 5);
        chk("z5_sample69", int'(rec_s[69]), 5);

        // Good frames of 3, a malformed 12-tick frame, then a stuck-high line
        start_test(4);
        send_frame(3, 16);
        send_frame(3, 16);
        send_frame(4, 12);
        do_tick(1'b1);
        chk("mal_valid17", int'(rec_v[17]), 1);
        chk("mal_sample33", int'(rec_s[33]), 3);
        chk("mal_err45", int'(rec_e[45]), 1);
        chk("mal_valid45", int'(rec_v[45]), 0);
        chk("mal_sample45", int'(rec_s[45]), 3);
        for (int i = 0; i < 48; i++) do_tick(1'b1);
        for (int i = 46; i <= 93; i++) begin
            chk("hi_err", int'(rec_e[i]), (i == 60 || i == 76 || i == 92) ? 1 : 0);
            chk("hi_valid", int'(rec_v[i]), 0);
        end
        chk("hi_sample", int'(rec_s[93]), 3);

        // Reset in the middle of a value-9 frame
        start_test(4);
        send_frame(9, 16);
        send_frame(9, 16);
        for (int i = 0; i < 8; i++) do_tick(1'b1);
        chk("pre_rst_sample", sample_o, 9);
        assert_rst();
        chk("mid_rst_sample", sample_o, 0);
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_err", err_o, 0);
        do_tick(1'b1);
        for (int i = 0; i < 3; i++) do_tick(1'b0);
        release_rst();
        for (int i = 0; i < 4; i++) do_tick(1'b0);
        send_frame(9, 16);
        send_frame(9, 16);
        do_tick(1'b1);
        cnt_v = 0; cnt_e = 0;
        for (int i = 45; i <= 81; i++) begin
            if (rec_v[i]) cnt_v++;
            if (rec_e[i]) cnt_e++;
        end
        chk("rst_discard_valid", int'(rec_v[49]), 0);
        chk("rst_discard_err", int'(rec_e[49]), 0);
        chk("rst_valid65", int'(rec_v[65]), 1);
        chk("rst_sample65", int'(rec_s[65]), 9);
        chk("rst_err_count", cnt_e, 0);
        chk("rst_valid_count", cnt_v, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
